// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encoding and sizing helpers for the shift-add multiplier
package mult_pkg;

    localparam int MULT_WIDTH = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // One spare bit so the counter can represent WIDTH itself.
    function automatic int mult_cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - sequential shift-add multiply-accumulate, P = A*B + C
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [WIDTH-1:0]   C,
    output logic [2*WIDTH-1:0] P,
    output logic               busy,
    output logic               done
);

    localparam int CW = mult_cnt_width(WIDTH);

    logic [1:0]         state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc_next;
    logic               last_step;

    // The addend preloads the accumulator, so the final sum never exceeds 2*WIDTH bits.
    always_comb begin
        acc_next  = mplier[0] ? (acc + mcand) : acc;
        last_step = (cnt == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            P      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc    <= {{WIDTH{1'b0}}, C};
                        mcand  <= {{WIDTH{1'b0}}, A};
                        mplier <= B;
                        cnt    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        P     <= acc_next;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - self-checking bench for mult_seq against a latency/arithmetic model
module tb_mult_seq;

    localparam int W = 16;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [W-1:0]   C;
    logic [2*W-1:0] P;
    logic           busy;
    logic           done;

    int n_cmp = 0;
    int n_err = 0;
    int dc    = 0;
    bit armed = 0;

    mult_seq #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (A),
        .B     (B),
        .C     (C),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: an accepted request yields A*B+C after exactly W busy cycles, then one done cycle.
    logic           m_busy;
    logic           m_done;
    logic [2*W-1:0] m_p;
    logic [2*W-1:0] m_pend;
    int             m_rem;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_p    <= '0;
            m_pend <= '0;
            m_rem  <= 0;
        end else if (m_busy) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_p    <= m_pend;
            end
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (start) begin
            m_busy <= 1'b1;
            m_rem  <= W;
            m_pend <= {{W{1'b0}}, A} * {{W{1'b0}}, B} + {{W{1'b0}}, C};
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (armed) begin
            chk("cyc_busy", 64'(busy), 64'(m_busy));
            chk("cyc_done", 64'(done), 64'(m_done));
            chk("cyc_p", 64'(P), 64'(m_p));
            chk("cyc_excl", 64'(busy & done), 64'd0);
            if (done) dc++;
        end
    end

    // Called at posedge+2; leaves the bench at (edge 0)+2 with operands scrambled.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
        A = a;
        B = b;
        C = c;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
        C = W'($urandom);
    endtask

    task automatic wait_done(input string nm, input logic [2*W-1:0] exp_p, input int exp_lat);
        int lat;
        bit found;
        lat = 0;
        found = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                lat = k;
                found = 1'b1;
                break;
            end
        end
        chk({nm, "_seen"}, 64'(found), 64'd1);
        chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({nm, "_p"}, 64'(P), 64'(exp_p));
        @(posedge clk);
        #2;
    endtask

    initial begin
        int dc0;
        rst_n = 1'b0;
        start = 1'b0;
        A = '0;
        B = '0;
        C = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_p", 64'(P), 64'd0);
        rst_n = 1'b1;
        armed = 1'b1;

        // Accepted at the first edge after reset release.
        launch(16'd3, 16'd5, 16'd2);
        chk("basic_busy_e0", 64'(busy), 64'd1);
        wait_done("basic", 32'd17, W + 1);
        chk("model_basic", 64'(m_p), 64'd17);

        launch(16'hFFFF, 16'hFFFF, 16'hFFFF);
        wait_done("maxv", 32'hFFFF0000, W + 1);

        launch(16'd142, 16'd7, 16'd6);
        wait_done("divrt", 32'd1000, W + 1);
        chk("model_divrt", 64'(m_p), 64'd1000);

        launch(16'd0, 16'd0, 16'h1234);
        wait_done("bzero", 32'h00001234, W + 1);

        launch(16'hABCD, 16'd0, 16'h1234);
        wait_done("bzero2", 32'h00001234, W + 1);

        // Start re-asserted with new operands mid-run must not disturb the result.
        dc0 = dc;
        launch(16'd3, 16'd5, 16'd2);
        repeat (4) @(posedge clk);
        #2;
        start = 1'b1;
        A = 16'd9;
        B = 16'd9;
        C = 16'd9;
        repeat (4) @(posedge clk);
        #2;
        start = 1'b0;
        wait_done("ignore", 32'd17, W - 8 + 1);
        repeat (5) @(posedge clk);
        #2;
        chk("ignore_pulses", 64'(dc - dc0), 64'd1);

        // Reset in the middle of a run aborts it immediately.
        launch(16'd100, 16'd200, 16'd3);
        repeat (8) @(posedge clk);
        #2;
        dc0 = dc;
        rst_n = 1'b0;
        #1;
        chk("abort_p", 64'(P), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        chk("abort_nopulse", 64'(dc - dc0), 64'd0);
        launch(16'd12, 16'd34, 16'd56);
        wait_done("after_rst", 32'd464, W + 1);

        launch(16'h8000, 16'h0002, 16'h0001);
        wait_done("carry", 32'h00010001, W + 1);

        repeat (3) @(posedge clk);
        armed = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
